// File: rtl/snn_pkg.sv
// Shared definitions for the SNN frame sequencer: frame geometry, sequencer
// states and the per-frame result record handed to the output port.
package snn_pkg;

    localparam int N_SAMPLES = 256;
    localparam int SAMPLE_W  = 6;
    localparam int CLASS_W   = 2;
    localparam int IDX_W     = 16;
    // Widest run-cycle counter a result record can carry; narrower counters
    // are zero-extended into it.
    localparam int CYC_W_MAX = 20;
    localparam int ADDR_W    = $clog2(N_SAMPLES);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [CLASS_W-1:0]   cls;
        logic                 no_spike;
        logic                 timeout;
        logic [CYC_W_MAX-1:0] cycles;
        logic [IDX_W-1:0]     frame_idx;
    } result_rec_t;

    // Assemble one result record from its fields.
    function automatic result_rec_t make_result(
        input logic [CLASS_W-1:0]   cls,
        input logic                 no_spike,
        input logic                 timeout,
        input logic [CYC_W_MAX-1:0] cycles,
        input logic [IDX_W-1:0]     frame_idx
    );
        result_rec_t rec;
        rec.cls       = cls;
        rec.no_spike  = no_spike;
        rec.timeout   = timeout;
        rec.cycles    = cycles;
        rec.frame_idx = frame_idx;
        return rec;
    endfunction

endpackage

// File: rtl/snn_result_reg.sv
// Valid/ready holding register for one result record. A load captures the
// record and raises valid; the record stays frozen until the consumer takes it.
module snn_result_reg
    import snn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  result_rec_t load_rec,
    input  logic        ready,
    output logic        valid,
    output result_rec_t rec
);

    logic        valid_r;
    result_rec_t rec_r;

    // Capture on load, drop valid after a completed handshake, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            rec_r   <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            rec_r   <= load_rec;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign rec   = rec_r;

endmodule

// File: rtl/snn_frame_sequencer.sv
// Host-side driver for the SNN ECG classifier core: loads one frame of
// period samples into the core, pulses the core through reset and run,
// and reports the classification of every frame on a valid/ready port.
module snn_frame_sequencer
    import snn_pkg::*;
#(
    parameter int RST_CYCLES = 3,
    parameter int CYC_W      = CYC_W_MAX
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                s_ready,
    output logic                core_wr_en,
    output logic [ADDR_W-1:0]   core_wr_addr,
    output logic [SAMPLE_W-1:0] core_wr_data,
    output logic                core_resetn,
    input  logic                core_end_process,
    input  logic [CLASS_W-1:0]  core_output_class,
    input  logic                core_no_spike,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [CLASS_W-1:0]  r_class,
    output logic                r_no_spike,
    output logic                r_timeout,
    output logic [CYC_W-1:0]    r_cycles,
    output logic [IDX_W-1:0]    r_frame_idx,
    output logic                busy
);

    // Hold counter must reach RST_CYCLES; keep at least one bit.
    localparam int HOLD_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_SAT = '1;

    seq_state_t          state_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [CYC_W-1:0]    cyc_r;
    logic [IDX_W-1:0]    frame_cnt_r;
    logic                s_ready_r;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [SAMPLE_W-1:0] wr_data_r;
    logic                core_rst_r;
    logic                busy_r;

    logic                accept_s;
    logic                load_s;
    result_rec_t         load_rec_s;
    logic                res_valid_s;
    result_rec_t         res_rec_s;
    logic                handshake_s;

    assign accept_s    = s_valid & s_ready_r & (state_r == LOAD);
    assign handshake_s = (state_r == REPORT) & res_valid_s & r_ready;

    // Decide whether this cycle closes the run and which record it produces
    always_comb begin
        load_s     = 1'b0;
        load_rec_s = '0;
        if (state_r == RUN) begin
            if (core_end_process) begin
                load_s     = 1'b1;
                load_rec_s = make_result(core_output_class, core_no_spike, 1'b0,
                                         CYC_W_MAX'(cyc_r), frame_cnt_r);
            end else if (cyc_r == CYC_SAT) begin
                // Core never finished: report a timeout with a neutral class.
                load_s     = 1'b1;
                load_rec_s = make_result({CLASS_W{1'b0}}, 1'b1, 1'b1,
                                         CYC_W_MAX'(CYC_SAT), frame_cnt_r);
            end else begin
                load_s     = 1'b0;
                load_rec_s = '0;
            end
        end else begin
            load_s     = 1'b0;
            load_rec_s = '0;
        end
    end

    // Frame sequencer FSM with its sample, hold, run and frame counters
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r     <= LOAD;
            cnt_r       <= '0;
            hold_cnt_r  <= '0;
            cyc_r       <= '0;
            frame_cnt_r <= '0;
            s_ready_r   <= 1'b1;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            core_rst_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= cnt_r;
                        wr_data_r <= s_data;
                        cnt_r     <= cnt_r + ADDR_W'(1);
                        busy_r    <= 1'b1;
                        if (cnt_r == ADDR_W'(N_SAMPLES - 1)) begin
                            state_r    <= HOLD;
                            s_ready_r  <= 1'b0;
                            hold_cnt_r <= '0;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                end
                HOLD: begin
                    // First HOLD cycle carries the final write; the core
                    // reset is then kept high for RST_CYCLES more cycles.
                    wr_en_r <= 1'b0;
                    if (hold_cnt_r == HOLD_W'(RST_CYCLES)) begin
                        core_rst_r <= 1'b0;
                        cyc_r      <= CYC_W'(1);
                        state_r    <= RUN;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (load_s) begin
                        core_rst_r <= 1'b1;
                        state_r    <= REPORT;
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1);
                    end
                end
                REPORT: begin
                    if (handshake_s) begin
                        state_r     <= LOAD;
                        s_ready_r   <= 1'b1;
                        frame_cnt_r <= frame_cnt_r + IDX_W'(1);
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= REPORT;
                    end
                end
                default: begin
                    state_r <= LOAD;
                end
            endcase
        end
    end

    snn_result_reg u_result_reg (
        .clk      (clk),
        .rst      (resetn),
        .load     (load_s),
        .load_rec (load_rec_s),
        .ready    (r_ready),
        .valid    (res_valid_s),
        .rec      (res_rec_s)
    );

    assign s_ready      = s_ready_r;
    assign core_wr_en   = wr_en_r;
    assign core_wr_addr = wr_addr_r;
    assign core_wr_data = wr_data_r;
    assign core_resetn  = core_rst_r;
    assign busy         = busy_r;
    assign r_valid      = res_valid_s;
    assign r_class      = res_rec_s.cls;
    assign r_no_spike   = res_rec_s.no_spike;
    assign r_timeout    = res_rec_s.timeout;
    assign r_cycles     = res_rec_s.cycles[CYC_W-1:0];
    assign r_frame_idx  = res_rec_s.frame_idx;

endmodule

// File: doc/snn_frame_sequencer.md
Name: snn_frame_sequencer

Overview:
- Hardware host-side driver for the SNN ECG classifier core; it performs in RTL the job the bench does today.
- Accepts a stream of 6-bit input-period samples and writes each 256-sample frame into the core's period memory.
- Sequences the core's reset and run phases, captures the core's class/no-spike result, and emits one result record per frame on a valid/ready port.
- Sits between the sample source (UART/DMA front end) and top.

Parameters:
N_SAMPLES, 256, samples per frame (power of two)
SAMPLE_W, 6, sample width
CLASS_W, 2, core output_class width
RST_CYCLES, 3, clk cycles core reset is held after the last frame write
CYC_W, 20, width of the run-cycle counter; saturation at all-ones means timeout
IDX_W, 16, frame index width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-high reset (name kept per codebase; high = reset)
s_valid  in  1  sample valid
s_data  in  SAMPLE_W  sample value
s_ready  out  1  sample accepted when s_valid & s_ready
core_wr_en  out  1  write strobe into core in_period memory
core_wr_addr  out  log2(N_SAMPLES)  write address
core_wr_data  out  SAMPLE_W  write data
core_resetn  out  1  core reset, active-high
core_end_process  in  1  core done flag
core_output_class  in  CLASS_W  core class
core_no_spike  in  1  core no-spike flag
r_valid  out  1  result valid
r_ready  in  1  result consumer ready
r_class  out  CLASS_W  captured class
r_no_spike  out  1  captured no-spike flag
r_timeout  out  1  core never asserted end_process
r_cycles  out  CYC_W  cycles from core reset release to end_process
r_frame_idx  out  IDX_W  frame number, starting at 0
busy  out  1  high in every state except LOAD with count 0

Behaviour:
- States: LOAD, HOLD, RUN, REPORT.
- Reset values: state = LOAD; s_ready = 1; core_resetn = 1; core_wr_en = 0; addr/data = 0; all r_* = 0; busy = 0; sample count = 0.
- LOAD:
  - s_ready = 1 and core_resetn = 1.
  - Each accepted sample is registered: core_wr_en pulses 1 cycle later, with addr = sample count and data = s_data.
  - The count increments per accepted sample.
  - On acceptance of sample N_SAMPLES-1: s_ready drops the next cycle, the count wraps to 0, and the state moves to HOLD.
  - No back-to-back gap is required; one sample per cycle is sustained.
- HOLD:
  - s_ready = 0 and core_resetn = 1.
  - The final write strobe is issued in the first HOLD cycle.
  - core_resetn stays high for RST_CYCLES cycles counted after that final write cycle, then goes low and the state moves to RUN.
- RUN:
  - core_resetn = 0; the cycle counter starts at 1 on the first RUN cycle.
  - If core_end_process = 1 at a clock edge: capture class, no_spike and the counter into the r_* registers; set r_timeout = 0; move to REPORT. r_valid goes high the next cycle (1-cycle latency).
  - If the counter reaches all-ones first: r_timeout = 1, r_class = 0, r_no_spike = 1, r_cycles = all-ones; move to REPORT.
- REPORT:
  - core_resetn = 1, asserted on entry, matching the core's need to be reset right after end_process.
  - r_valid is held with the r_* fields stable until r_ready = 1.
  - On handshake: r_valid drops next cycle, r_frame_idx increments (wrapping at 2^IDX_W), and the state returns to LOAD.
  - The next frame's samples are not accepted until LOAD; this gives back-pressure via s_ready.
- core_end_process outside RUN is ignored.
- s_valid outside LOAD is ignored; no sample is lost, because s_ready = 0.
- r_ready while r_valid = 0 has no effect.
- Asynchronous resetn in any state: immediate return to reset values. A partially loaded frame is discarded, and r_frame_idx returns to 0.
- Arithmetic:
  - All counters are unsigned.
  - The sample count is exactly log2(N_SAMPLES) bits and wraps naturally.
  - The cycle counter saturates at timeout and never wraps.

Decomposition:
- Shared package snn_pkg:
  - constants N_SAMPLES, SAMPLE_W, CLASS_W;
  - the state enum (LOAD, HOLD, RUN, REPORT);
  - the result record struct (class, no_spike, timeout, cycles, frame_idx).
- One sub-module: snn_result_reg, the valid/ready output holding register, reusable for the UART result path.
- The FSM and counters stay in snn_frame_sequencer.

Test Plan:
- Reset, then 256 samples 0x00..0x3F repeating, s_valid held high -> 256 core_wr_en pulses, addr 0..255, data equal to the sample; s_ready = 0 from the cycle after sample 255; core_resetn falls exactly RST_CYCLES = 3 cycles after the last write.
- Core model asserts end_process 40 cycles after release with class = 2, no_spike = 0 -> next cycle r_valid = 1, r_class = 2, r_no_spike = 0, r_cycles = 40, r_frame_idx = 0, core_resetn = 1.
- r_ready held low 10 cycles, then high -> r_* stable for the whole wait; one handshake; r_frame_idx = 1 on the next frame; s_ready returns to 1.
- Core never asserts end_process with CYC_W = 8 -> r_timeout = 1, r_cycles = 0xFF, r_class = 0, r_no_spike = 1.
- Random s_valid gaps (50% duty) plus end_process pulsed during LOAD -> writes contiguous and in order, spurious end_process ignored, result identical to the gap-free run.
- resetn pulsed after 100 samples, then a full frame -> addresses restart at 0, exactly 256 writes, r_frame_idx = 0.
